ps2_mouse_decoder: RTL and testbench

- Receives the PS/2 mouse serial stream as a device-to-host receiver and frames 11-bit bytes into 3-byte movement packets.
- Keeps an absolute cursor position clamped to the 640x480 VGA screen and produces a single-cycle left-click pulse.
- Feeds the screen FSM and game logic with x, y and click for play-button, difficulty-button and hole hit-testing.
- Receive-only; mouse initialisation/stream enable is not in this block (mouse powers up in stream mode after the host stops inhibiting).

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_rx_byte.sv | 149 ++++++++++++++
 rtl/ps2_mouse_decoder.sv | 128 ++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 mouse receive path.
package ps2_pkg;

    // Bit positions inside the first (header) byte of a movement packet
    localparam int unsigned B0_LEFT = 0;
    localparam int unsigned B0_SYNC = 3;
    localparam int unsigned B0_XS   = 4;
    localparam int unsigned B0_YS   = 5;
    localparam int unsigned B0_XO   = 6;
    localparam int unsigned B0_YO   = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Only the header fields the position update needs are kept
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic left;
    } pkt_hdr_t;

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: input synchronizers, ps2_clk glitch
// filter, 11-bit frame FSM and a mid-frame inactivity watchdog.
//
// state  | meaning
// IDLE   | waiting for a start bit (strobe with data=0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then emitting the byte or an error
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  clk_filt;
    logic                  clk_filt_d;
    logic                  strobe;
    logic                  dat;
    rx_state_t             state;
    rx_state_t             state_nx;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic                  par_bit;
    logic [WD_W-1:0]       wd_cnt;
    logic                  timeout;
    logic                  rx_done;
    logic                  frame_ok;

    assign strobe = clk_filt_d & ~clk_filt;
    assign dat    = dat_sync[1];

    // Two-flop synchronizers for both PS/2 lines (idle high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // Filtered clock changes level only after FILTER_LEN identical samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_hist   <= '1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
            clk_filt_d <= clk_filt;
            if (&clk_hist) begin
                clk_filt <= 1'b1;
            end else if (~|clk_hist) begin
                clk_filt <= 1'b0;
            end
        end
    end

    // Watchdog down-counter, reloaded while idle and on every strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
        end else if (state == IDLE || strobe) begin
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a timeout abandons the partial frame from any state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (strobe && !dat)              state_nx = DATA;
            DATA:    if (strobe && bit_cnt == 3'd7)   state_nx = PARITY;
            PARITY:  if (strobe)                      state_nx = STOP;
            STOP:    if (strobe)                      state_nx = IDLE;
            default:                                  state_nx = IDLE;
        endcase
        if (timeout) begin
            state_nx = IDLE;
        end
    end

    // Output decode: end-of-frame, frame validity and watchdog expiry
    always_comb begin
        rx_done  = (state == STOP) && strobe;
        frame_ok = dat && (^{shift, par_bit});
        timeout  = (state != IDLE) && !strobe && (wd_cnt == '0);
    end

    // Bit shifter and parity capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            par_bit <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (strobe) begin
            if (state == DATA) begin
                shift   <= {dat, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (state == PARITY) begin
                par_bit <= dat;
            end
        end
    end

    // Registered byte/error outputs, one cycle after the stop strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= rx_done & frame_ok;
            err        <= (rx_done & ~frame_ok) | timeout;
            if (rx_done) begin
                rx_byte <= shift;
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse decoder: frames received bytes into 3-byte movement packets
// and keeps a cursor position clamped to the visible screen.
module ps2_mouse_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FILTER_LEN  = 4,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       left_btn,
    output logic       click,
    output logic       pkt_valid,
    output logic       frame_err
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_err;
    logic [1:0]  byte_idx;
    pkt_hdr_t    hdr;
    logic [7:0]  dx_lo;
    logic [11:0] dx;
    logic [11:0] dy;
    logic [11:0] x_sum;
    logic [11:0] y_diff;
    logic [9:0]  x_next;
    logic [8:0]  y_next;

    ps2_rx_byte #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .FILTER_LEN  (FILTER_LEN)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    // 12-bit two's-complement position arithmetic with screen clamping;
    // dy comes straight from byte2 as it arrives
    always_comb begin
        dx     = {{4{hdr.xs}}, dx_lo};
        dy     = {{4{hdr.ys}}, rx_byte};
        x_sum  = {2'b00, x} + dx;
        y_diff = {3'b000, y} - dy;
        if (x_sum[11]) begin
            x_next = '0;
        end else if (x_sum > 12'(X_MAX)) begin
            x_next = 10'(X_MAX);
        end else begin
            x_next = x_sum[9:0];
        end
        if (y_diff[11]) begin
            y_next = '0;
        end else if (y_diff > 12'(Y_MAX)) begin
            y_next = 9'(Y_MAX);
        end else begin
            y_next = y_diff[8:0];
        end
    end

    // Packet assembly, header resync and position/button update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx  <= 2'd0;
            hdr       <= '0;
            dx_lo     <= 8'd0;
            x         <= 10'(X_INIT);
            y         <= 9'(Y_INIT);
            left_btn  <= 1'b0;
            click     <= 1'b0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            click     <= 1'b0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
            if (rx_err) begin
                frame_err <= 1'b1;
                byte_idx  <= 2'd0;
            end else if (rx_valid) begin
                case (byte_idx)
                    2'd0: begin
                        if (rx_byte[B0_SYNC]) begin
                            hdr.left <= rx_byte[B0_LEFT];
                            hdr.xs   <= rx_byte[B0_XS];
                            hdr.ys   <= rx_byte[B0_YS];
                            hdr.xo   <= rx_byte[B0_XO];
                            hdr.yo   <= rx_byte[B0_YO];
                            byte_idx <= 2'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    2'd1: begin
                        dx_lo    <= rx_byte;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        byte_idx  <= 2'd0;
                        pkt_valid <= 1'b1;
                        if (!hdr.xo) begin
                            x <= x_next;
                        end
                        if (!hdr.yo) begin
                            y <= y_next;
                        end
                        left_btn <= hdr.left;
                        click    <= hdr.left & ~left_btn;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: directed scenarios plus random packet
// streams, compared against a byte-stream reference model.
module tb_ps2_mouse_decoder;

    localparam int TIMEOUT = 1000;
    localparam int HALF    = 12;
    localparam int GAP     = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] x;
    logic [8:0] y;
    logic       left_btn;
    logic       click;
    logic       pkt_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int n_pkt = 0;
    int n_click = 0;
    int n_ferr = 0;

    int         m_x, m_y, m_left, m_idx;
    logic [7:0] m_b0, m_b1;
    int         e_pkt = 0;
    int         e_click = 0;
    int         e_ferr = 0;

    ps2_mouse_decoder #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .x         (x),
        .y         (y),
        .left_btn  (left_btn),
        .click     (click),
        .pkt_valid (pkt_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output; a stretched pulse over-counts
    always @(negedge clk) begin
        if (reset_n) begin
            if (pkt_valid) n_pkt++;
            if (click)     n_click++;
            if (frame_err) n_ferr++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 320; m_y = 240; m_left = 0; m_idx = 0;
        m_b0 = 8'd0; m_b1 = 8'd0;
    endtask

    // Reference: byte-level packet rules applied with plain integers
    task automatic model_byte(input logic [7:0] b, input bit bad);
        int dx, dy;
        if (bad) begin
            e_ferr++;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin m_b0 = b; m_idx = 1; end
            else e_ferr++;
        end else if (m_idx == 1) begin
            m_b1 = b; m_idx = 2;
        end else begin
            dx = m_b0[4] ? int'(m_b1) - 256 : int'(m_b1);
            dy = m_b0[5] ? int'(b) - 256 : int'(b);
            if (!m_b0[6]) m_x = clampi(m_x + dx, 639);
            if (!m_b0[7]) m_y = clampi(m_y - dy, 479);
            if (m_b0[0] && m_left == 0) e_click++;
            m_left = int'(m_b0[0]);
            e_pkt++;
            m_idx = 0;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "/x"}, int'(x), m_x);
        check_eq({tag, "/y"}, int'(y), m_y);
        check_eq({tag, "/left"}, int'(left_btn), m_left);
        check_eq({tag, "/npkt"}, n_pkt, e_pkt);
        check_eq({tag, "/nclick"}, n_click, e_click);
        check_eq({tag, "/nferr"}, n_ferr, e_ferr);
    endtask

    // One PS/2 bit; optionally counts negedges from the falling clock edge
    // to the first pkt_valid (-1 if none during the low phase)
    task automatic ps2_bit(input logic b, input bit meas, output int lat);
        int k;
        lat = -1;
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        k = 0;
        while (k < HALF) begin
            @(negedge clk);
            k++;
            if (meas && lat < 0 && pkt_valid) lat = k;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad, input bit meas, output int lat);
        int dummy;
        ps2_bit(1'b0, 1'b0, dummy);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, dummy);
        ps2_bit((~^b) ^ bad, 1'b0, dummy);
        ps2_bit(1'b1, meas, lat);
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        model_byte(b, bad);
    endtask

    task automatic tx(input logic [7:0] b, input bit bad, input string tag);
        int lat;
        send_byte(b, bad, 1'b0, lat);
        check_state(tag);
    endtask

    task automatic tx_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input string tag);
        tx(b0, 1'b0, {tag, ".b0"});
        tx(b1, 1'b0, {tag, ".b1"});
        tx(b2, 1'b0, {tag, ".b2"});
    endtask

    task automatic partial_bits(input int nbits);
        int dummy;
        ps2_bit(1'b0, 1'b0, dummy);
        for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0, dummy);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat;
        int c0;
        logic [7:0] rb0, rb1, rb2;

        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst.x", int'(x), 320);
        check_eq("rst.y", int'(y), 240);
        check_eq("rst.left", int'(left_btn), 0);
        check_eq("rst.click", int'(click), 0);
        check_eq("rst.pkt_valid", int'(pkt_valid), 0);
        check_eq("rst.frame_err", int'(frame_err), 0);
        do_reset();

        // Basic move; the last byte also measures falling-edge-to-apply delay:
        // 2 sync + FILTER_LEN samples + filtered edge register + 2 cycles
        tx(8'h08, 1'b0, "t1.b0");
        tx(8'h0A, 1'b0, "t1.b1");
        send_byte(8'h05, 1'b0, 1'b1, lat);
        check_state("t1.b2");
        check_eq("t1.latency", lat, 9);
        check_eq("t1.x_abs", int'(x), 330);
        check_eq("t1.y_abs", int'(y), 235);

        // Click: press, hold, release
        c0 = n_click;
        tx_pkt(8'h09, 8'h00, 8'h00, "t2.press");
        check_eq("t2.left_after_press", int'(left_btn), 1);
        tx_pkt(8'h09, 8'h00, 8'h00, "t2.hold");
        tx_pkt(8'h08, 8'h00, 8'h00, "t2.release");
        check_eq("t2.left_after_release", int'(left_btn), 0);
        check_eq("t2.click_count", n_click - c0, 1);

        // Clamping on both axes
        do_reset();
        tx_pkt(8'h18, 8'h00, 8'h00, "t3.xneg1");
        check_eq("t3.x64", int'(x), 64);
        tx_pkt(8'h18, 8'h00, 8'h00, "t3.xneg2");
        check_eq("t3.x0", int'(x), 0);
        tx_pkt(8'h28, 8'h00, 8'h00, "t3.yneg1");
        tx_pkt(8'h28, 8'h00, 8'h00, "t3.yneg2");
        check_eq("t3.ymax", int'(y), 479);

        // Bad parity on byte1, then a clean packet
        tx(8'h08, 1'b0, "t4.b0");
        tx(8'h33, 1'b1, "t4.badpar");
        tx_pkt(8'h08, 8'h05, 8'h03, "t4.good");

        // Header without sync bit, then a clean packet
        do_reset();
        tx(8'h02, 1'b0, "t5.nosync");
        tx_pkt(8'h08, 8'h01, 8'h00, "t5.good");
        check_eq("t5.x321", int'(x), 321);

        // Mid-frame timeout after an accepted header
        tx(8'h09, 1'b0, "t6.b0");
        partial_bits(5);
        repeat (TIMEOUT + 10) @(negedge clk);
        e_ferr++;
        m_idx = 0;
        check_state("t6.timeout");
        tx_pkt(8'h08, 8'h07, 8'h02, "t6.good");

        // Asynchronous reset in the middle of a byte
        partial_bits(5);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t7.x_rst", int'(x), 320);
        check_eq("t7.y_rst", int'(y), 240);
        check_eq("t7.left_rst", int'(left_btn), 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        tx_pkt(8'h08, 8'hFF, 8'h01, "t7.good");

        // Random packets with occasional sync, overflow and parity faults
        for (int p = 0; p < 40; p++) begin
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            rb2 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) rb0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) rb0[7:6] = 2'b00;
            tx(rb0, $urandom_range(0, 15) == 0, "rnd.b0");
            tx(rb1, $urandom_range(0, 15) == 0, "rnd.b1");
            tx(rb2, $urandom_range(0, 15) == 0, "rnd.b2");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
